spi_controller: RTL

- SPI controller (initiator) that drives CS_n, SCLK and MOSI, and samples MISO.
- It is the far end of the SPI peripheral link; the peripheral's edge detectors consume the SCLK and CS_n edges this block generates.
- Fixed SPI mode 0: SCLK idles low, MOSI launched on the SCLK falling edge, MISO sampled on the SCLK rising edge.
- Used on-chip and in benches to exercise the SPI peripheral register interface.

---
 rtl/spi_ctrl_pkg.sv | 15 +
 rtl/spi_clk_divider.sv | 30 +++
 rtl/spi_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI controller (mode 0 initiator).
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_clk_divider.sv
// Half-period tick generator: a loadable down-counter that emits a one-cycle
// tick every div+1 enabled cycles. restart reloads the count so the first tick
// lands exactly div+1 cycles later. The counter never wraps past div, so
// div = all-ones gives a period of 2^DIV_W without overflow.
module spi_clk_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Count down to zero, reload on restart or on reaching zero; hold when disabled.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (ena) begin
      if (restart || (cnt == '0)) cnt <= div;
      else                        cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = ena && !restart && (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 controller: drives spi_cs_n / spi_sclk / spi_mosi, samples spi_miso.
// Optional macro SPI_CTRL_LSB_FIRST_EN adds the lsb_first input (bit order select,
// latched at start acceptance); without it the bit order is always MSB first.
//
// Handshake: start is only looked at in IDLE with ena high; that edge accepts the
// request (tx_data, div, lsb_first latched). busy is high from the next cycle up
// to and including the done cycle; done pulses for one cycle with rx_data valid
// from that cycle until the next done. start while busy is dropped, not queued.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
`ifdef SPI_CTRL_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output state_t           dbg_state
);

  // Toggle counter spans 0..2*WIDTH; 2*WIDTH means "all edges sent, trailing low half".
  localparam int TOG_W = $clog2(2*WIDTH+1);
  localparam logic [TOG_W-1:0] TOG_END       = TOG_W'(2*WIDTH);
  localparam logic [TOG_W-1:0] TOG_LAST_FALL = TOG_W'(2*WIDTH-1);

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_q, div_sel;
  logic [WIDTH-1:0] tx_sr, rx_sr;
  logic [TOG_W-1:0] tog;
  logic             tick, accept, rise_evt, fall_evt, hold_end;
  logic             lsb_in, lsb_q;

`ifdef SPI_CTRL_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Live div is used only on the accept edge; afterwards the latched copy rules.
  assign div_sel  = (state == IDLE) ? div : div_q;
  assign accept   = (state == IDLE) && start;
  assign rise_evt = tick && ((state == SETUP) ||
                    ((state == SHIFT) && (tog != TOG_END) && !spi_sclk));
  assign fall_evt = tick && (state == SHIFT) && (tog != TOG_END) && spi_sclk;
  assign hold_end = tick && (state == HOLD);

  spi_clk_divider #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .restart (accept),
    .div     (div_sel),
    .tick    (tick)
  );

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk) begin
    if (!rstb)    state <= IDLE;
    else if (ena) state <= state_nx;
  end

  // Next-state: each phase advances on a half-period tick, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)                   state_nx = SETUP;
      SETUP:   if (tick)                    state_nx = SHIFT;
      SHIFT:   if (tick && tog == TOG_END)  state_nx = HOLD;
      HOLD:    if (tick)                    state_nx = DONE;
      DONE:                                 state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Serial datapath: SCLK/CS_n/MOSI registered, shift registers, rx capture.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      spi_cs_n <= CS_IDLE;
      spi_sclk <= SCLK_IDLE;
      spi_mosi <= 1'b0;
      rx_data  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      div_q    <= '0;
      tog      <= '0;
      lsb_q    <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        tx_sr    <= tx_data;
        div_q    <= div;
        lsb_q    <= lsb_in;
        tog      <= '0;
        spi_cs_n <= ~CS_IDLE;
        spi_mosi <= lsb_in ? tx_data[0] : tx_data[WIDTH-1];
      end
      if (rise_evt) begin
        spi_sclk <= 1'b1;
        tog      <= tog + TOG_W'(1);
        rx_sr    <= lsb_q ? {spi_miso, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], spi_miso};
      end
      if (fall_evt) begin
        spi_sclk <= SCLK_IDLE;
        tog      <= tog + TOG_W'(1);
        if (tog != TOG_LAST_FALL) begin
          tx_sr    <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
          spi_mosi <= lsb_q ? tx_sr[1] : tx_sr[WIDTH-2];
        end
      end
      if (hold_end) begin
        rx_data  <= rx_sr;
        spi_cs_n <= CS_IDLE;
        spi_mosi <= 1'b0;
      end
    end
  end

endmodule
